store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Post-commit store buffer between the LSQ store-queue head and the DCache write port.
- The LSQ retires a committed store into this FIFO in one cycle. The buffer then drains entries to the DCache in order, one at a time, and holds each one until the DCache acks it.
- It also gives the load queue a combinational forwarding and conflict check against every buffered store, so that loads never read stale cache data.

Parameters:
- DEPTH, 8, number of buffered committed stores; power of 2, at least 2.
- ADDR_W, 16, byte address width, split as {tag[7:0], idx[4:0], offset[2:0]}.
- DATA_W, 64, store data width.

Ports:
- clock, in, 1, single clock; all state updates on posedge.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, committed store presented by the SQ head.
- in_addr, in, ADDR_W, store byte address.
- in_data, in, DATA_W, store data, right-aligned (bytes in the low 2^size positions).
- in_size, in, 2, MEM_SIZE: BYTE=0, HALF=1, WORD=2, DOUBLE=3.
- in_ready, out, 1, buffer can accept a store this cycle.
- dc_wr_en, out, 1, head entry is valid and is being presented to the DCache.
- dc_wr_tag, out, 8, head address tag.
- dc_wr_idx, out, 5, head address index.
- dc_wr_offset, out, 3, head address byte offset.
- dc_wr_data, out, DATA_W, head data.
- dc_wr_size, out, 2, head size.
- dc_wr_ack, in, 1, DCache accepted the head write this cycle.
- ld_chk_valid, in, 1, load-address check request.
- ld_chk_addr, in, ADDR_W, load byte address.
- ld_chk_size, in, 2, load MEM_SIZE.
- ld_fwd_hit, out, 1, youngest overlapping store fully covers the load.
- ld_fwd_data, out, DATA_W, forwarded load data, right-aligned and zero-extended.
- ld_conflict, out, 1, youngest overlapping store only partially covers the load; the load must retry.
- count, out, $clog2(DEPTH)+1, number of occupied entries.
- empty, out, 1, count == 0.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {addr, data, size}.
  - Head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - A registered count runs from 0 to DEPTH.
- Reset, synchronous: head = tail = count = 0; all entry valid bits cleared. This takes priority over enqueue and ack in the same cycle.
- Reset values of outputs: in_ready = 1, dc_wr_en = 0, dc_wr_* fields = 0, ld_fwd_hit = 0, ld_fwd_data = 0, ld_conflict = 0, count = 0, empty = 1.
- in_ready:
  - in_ready = (count < DEPTH), computed from registered state only.
  - When full, an ack in the same cycle does NOT open a slot; enqueue resumes the next cycle.
- Enqueue:
  - Occurs when in_valid && in_ready. The entry is written at tail and tail is incremented.
  - in_valid while in_ready = 0 is ignored; the SQ holds the store and re-presents it.
- Drain:
  - dc_wr_en = !empty.
  - dc_wr_* are driven combinationally from the head entry's registers and stay stable until acked.
  - Dequeue occurs when dc_wr_en && dc_wr_ack. Head is incremented and count is decremented.
  - dc_wr_ack while empty is ignored.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Write latency:
  - A store enqueued in cycle N appears on dc_wr_* in cycle N+1 if the buffer was empty.
  - The DCache sees at most one write per cycle.
- Exceptions: there is no except input. Buffered stores are architecturally committed and always drain; a pipeline flush never discards them.
- Forward check (combinational; only valid when ld_chk_valid, otherwise all three outputs are 0):
  - Every access is naturally aligned. A store and a load can overlap only if addr[15:3] are equal.
  - Byte ranges: store occupies [s_off, s_off + 2^s_size); load occupies [l_off, l_off + 2^l_size).
  - Scan registered entries from youngest (tail-1) to oldest (head). Select the first entry that overlaps the load.
  - If the selected entry covers the load range: ld_fwd_hit = 1 and ld_fwd_data = (data >> 8*(l_off - s_off)) masked to 2^l_size bytes; upper bits are 0. Sign extension is done by the LQ.
  - If the selected entry overlaps but does not cover: ld_conflict = 1 and ld_fwd_hit = 0.
  - If no entry overlaps, all three outputs are 0.
  - A store being enqueued in the same cycle is not visible to the check.
  - The head entry being acked in the same cycle is still visible to the check.
- Wrap-around: the scan follows pointer order, not index order. It must be correct when tail < head.

Decomposition:
- lsq_pkg holds:
  - MEM_SIZE typedef and the BYTE/HALF/WORD/DOUBLE constants;
  - dc_addr_t struct {tag[7:0], idx[4:0], offset[2:0]};
  - scb_entry_t {dc_addr_t addr; logic [63:0] data; MEM_SIZE size};
  - the DEPTH default.
- One sub-module, store_fwd_cmp: per-entry combinational compare taking entry and load address/size, producing overlap, cover and shifted data. It is instantiated DEPTH times; the top level performs the youngest-first priority select.

Test Plan:
- Reset, then enqueue a WORD to 0x1234 with data 0xDEADBEEF and hold dc_wr_ack = 0 -> next cycle dc_wr_en = 1, tag 0x12, idx 0x06, offset 4, data stable for 3 cycles; ack -> empty = 1 next cycle.
- Fill 8 entries with no ack -> count = 8, in_ready = 0. Present a 9th store with ack asserted in the same cycle -> 9th not accepted, count = 7. Next cycle the 9th is accepted and count = 8.
- Buffer holds DOUBLE @0x0100 data 0x1122334455667788; load HALF @0x0102 -> ld_fwd_hit = 1, ld_fwd_data = 0x5566.
- Buffer holds older DOUBLE @0x0100 and younger BYTE @0x0101; load WORD @0x0100 -> ld_conflict = 1, ld_fwd_hit = 0.
- Wrap: enqueue and drain 6, then enqueue 5 (tail wraps); two stores to 0x0200 with data 0xAA then 0xBB straddle the wrap; load BYTE @0x0200 -> ld_fwd_data = 0xBB.
- Assert reset with 4 entries buffered and ack high -> next cycle count = 0, dc_wr_en = 0, in_ready = 1.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types for the post-commit store path: access sizes, DCache address
// split and the store commit buffer entry layout.
package lsq_pkg;

  localparam int SCB_DEPTH  = 8;
  localparam int SCB_ADDR_W = 16;
  localparam int SCB_DATA_W = 64;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic [7:0] tag;
    logic [4:0] idx;
    logic [2:0] offset;
  } dc_addr_t;

  typedef struct packed {
    dc_addr_t    addr;
    logic [63:0] data;
    MEM_SIZE     size;
  } scb_entry_t;

  // Access length in bytes (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input MEM_SIZE s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/store_fwd_cmp.sv
// Compares one buffered store against a load: byte-range overlap, full
// coverage, and the store data realigned to the load's offset.
module store_fwd_cmp
  import lsq_pkg::*;
(
  input  scb_entry_t  entry_i,
  input  logic        entry_valid_i,
  input  dc_addr_t    ld_addr_i,
  input  MEM_SIZE     ld_size_i,
  output logic        overlap_o,
  output logic        cover_o,
  output logic [63:0] data_o
);

  logic        same_line;
  logic [3:0]  s_lo, s_hi, l_lo, l_hi;
  logic [2:0]  off_diff;
  logic [5:0]  shamt;
  logic [63:0] shifted;

  // Naturally aligned accesses never cross an 8-byte line, so overlap needs
  // the same tag/idx and intersecting byte ranges within that line.
  assign same_line = (entry_i.addr.tag == ld_addr_i.tag) &&
                     (entry_i.addr.idx == ld_addr_i.idx);

  assign s_lo = {1'b0, entry_i.addr.offset};
  assign s_hi = s_lo + size_bytes(entry_i.size);
  assign l_lo = {1'b0, ld_addr_i.offset};
  assign l_hi = l_lo + size_bytes(ld_size_i);

  assign overlap_o = entry_valid_i && same_line && (s_lo < l_hi) && (l_lo < s_hi);
  assign cover_o   = overlap_o && (s_lo <= l_lo) && (l_hi <= s_hi);

  // Only meaningful when covered, where the load offset is >= the store offset.
  assign off_diff = ld_addr_i.offset - entry_i.addr.offset;
  assign shamt    = {off_diff, 3'b000};
  assign shifted  = entry_i.data >> shamt;

  always_comb begin
    data_o = '0;
    case (ld_size_i)
      BYTE:   data_o[7:0]  = shifted[7:0];
      HALF:   data_o[15:0] = shifted[15:0];
      WORD:   data_o[31:0] = shifted[31:0];
      DOUBLE: data_o       = shifted;
    endcase
  end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order FIFO of committed stores draining to the DCache write port, with a
// combinational youngest-first forwarding/conflict check for loads.
module store_commit_buffer
  import lsq_pkg::*;
#(
  parameter int DEPTH  = SCB_DEPTH,
  parameter int ADDR_W = SCB_ADDR_W,
  parameter int DATA_W = SCB_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               in_size,
  output logic                     in_ready,
  output logic                     dc_wr_en,
  output logic [7:0]               dc_wr_tag,
  output logic [4:0]               dc_wr_idx,
  output logic [2:0]               dc_wr_offset,
  output logic [DATA_W-1:0]        dc_wr_data,
  output logic [1:0]               dc_wr_size,
  input  logic                     dc_wr_ack,
  input  logic                     ld_chk_valid,
  input  logic [ADDR_W-1:0]        ld_chk_addr,
  input  logic [1:0]               ld_chk_size,
  output logic                     ld_fwd_hit,
  output logic [DATA_W-1:0]        ld_fwd_data,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  scb_entry_t         ent_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  scb_entry_t         new_ent;
  scb_entry_t         head_ent;
  logic               enq, deq;

  // Handshakes: a store moves in when in_valid && in_ready; the head moves out
  // when dc_wr_en && dc_wr_ack. in_ready depends on registered count only, so
  // an ack while full frees the slot for the following cycle, not this one.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign enq      = in_valid && in_ready;
  assign deq      = dc_wr_en && dc_wr_ack;

  assign new_ent.addr = dc_addr_t'(in_addr);
  assign new_ent.data = in_data;
  assign new_ent.size = MEM_SIZE'(in_size);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) vld_q[tail_q] <= 1'b1;
      if (deq) vld_q[head_q] <= 1'b0;
    end
  end

  // Payload storage needs no reset; vld_q and count_q qualify every use.
  always_ff @(posedge clock) begin
    if (enq) ent_q[tail_q] <= new_ent;
  end

  assign head_ent     = ent_q[head_q];
  assign dc_wr_en     = !empty;
  assign dc_wr_tag    = dc_wr_en ? head_ent.addr.tag    : '0;
  assign dc_wr_idx    = dc_wr_en ? head_ent.addr.idx    : '0;
  assign dc_wr_offset = dc_wr_en ? head_ent.addr.offset : '0;
  assign dc_wr_data   = dc_wr_en ? head_ent.data        : '0;
  assign dc_wr_size   = dc_wr_en ? head_ent.size        : '0;

  dc_addr_t           ld_addr;
  MEM_SIZE            ld_size;
  logic [DEPTH-1:0]   cmp_ovl;
  logic [DEPTH-1:0]   cmp_cov;
  logic [63:0]        cmp_data [DEPTH];

  assign ld_addr = dc_addr_t'(ld_chk_addr);
  assign ld_size = MEM_SIZE'(ld_chk_size);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    store_fwd_cmp u_cmp (
      .entry_i       (ent_q[g]),
      .entry_valid_i (vld_q[g]),
      .ld_addr_i     (ld_addr),
      .ld_size_i     (ld_size),
      .overlap_o     (cmp_ovl[g]),
      .cover_o       (cmp_cov[g]),
      .data_o        (cmp_data[g])
    );
  end

  logic             sel_found;
  logic [PTR_W-1:0] sel_slot;
  logic             sel_hit;
  logic             sel_conflict;
  logic [63:0]      sel_data;

  // Walk in pointer order from tail-1 back to head so wrap-around is handled;
  // the first overlapping entry is the youngest and alone decides the result.
  always_comb begin
    sel_found    = 1'b0;
    sel_slot     = '0;
    sel_hit      = 1'b0;
    sel_conflict = 1'b0;
    sel_data     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sel_slot = tail_q - PTR_W'(k) - PTR_W'(1);
      if (!sel_found && (CNT_W'(k) < count_q) && cmp_ovl[sel_slot]) begin
        sel_found = 1'b1;
        if (cmp_cov[sel_slot]) begin
          sel_hit  = 1'b1;
          sel_data = cmp_data[sel_slot];
        end else begin
          sel_conflict = 1'b1;
        end
      end
    end
  end

  assign ld_fwd_hit  = ld_chk_valid && sel_hit;
  assign ld_conflict = ld_chk_valid && sel_conflict;
  assign ld_fwd_data = ld_fwd_hit ? sel_data : '0;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: DCache writes are checked by a
// scoreboard monitor, buffer state and load checks by direct comparisons.
module tb_store_commit_buffer;

  localparam int W = 16 + 64 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [15:0] in_addr;
  logic [63:0] in_data;
  logic [1:0]  in_size;
  logic        dc_wr_en, dc_wr_ack;
  logic [7:0]  dc_wr_tag;
  logic [4:0]  dc_wr_idx;
  logic [2:0]  dc_wr_offset;
  logic [63:0] dc_wr_data;
  logic [1:0]  dc_wr_size;
  logic        ld_chk_valid, ld_fwd_hit, ld_conflict;
  logic [15:0] ld_chk_addr;
  logic [1:0]  ld_chk_size;
  logic [63:0] ld_fwd_data;
  logic [3:0]  count;
  logic        empty;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got, mon_exp;

  store_commit_buffer dut (
    .clock        (clk),
    .reset        (rst),
    .in_valid     (in_valid),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_size      (in_size),
    .in_ready     (in_ready),
    .dc_wr_en     (dc_wr_en),
    .dc_wr_tag    (dc_wr_tag),
    .dc_wr_idx    (dc_wr_idx),
    .dc_wr_offset (dc_wr_offset),
    .dc_wr_data   (dc_wr_data),
    .dc_wr_size   (dc_wr_size),
    .dc_wr_ack    (dc_wr_ack),
    .ld_chk_valid (ld_chk_valid),
    .ld_chk_addr  (ld_chk_addr),
    .ld_chk_size  (ld_chk_size),
    .ld_fwd_hit   (ld_fwd_hit),
    .ld_fwd_data  (ld_fwd_data),
    .ld_conflict  (ld_conflict),
    .count        (count),
    .empty        (empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    exp_q.push_back({a, d, s});
  endtask

  task automatic set_load(input logic v, input logic [15:0] a, input logic [1:0] s);
    ld_chk_valid = v;
    ld_chk_addr  = a;
    ld_chk_size  = s;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && dc_wr_en && dc_wr_ack) begin
      n_vec++;
      mon_got = {dc_wr_tag, dc_wr_idx, dc_wr_offset, dc_wr_data, dc_wr_size};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dc_write: got unexpected write 0x%0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL dc_write: got 0x%0h expected 0x%0h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_valid = 1'b0; in_addr = '0; in_data = '0; in_size = '0;
    dc_wr_ack = 1'b0;
    set_load(1'b1, 16'h1234, 2'd2);
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dc_wr_en", dc_wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dc_wr_tag", dc_wr_tag, 0);
    chk("rst_dc_wr_data", dc_wr_data, 0);
    chk("rst_fwd_hit", ld_fwd_hit, 0);
    chk("rst_conflict", ld_conflict, 0);
    tick();
    rst = 1'b0;
    set_load(1'b0, 16'h0, 2'd0);

    // Single WORD store, held without ack for three cycles.
    push_store(16'h1234, 64'hDEADBEEF, 2'd2);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_wr_en", dc_wr_en, 1);
      chk("t1_tag", dc_wr_tag, 8'h12);
      chk("t1_idx", dc_wr_idx, 5'h06);
      chk("t1_offset", dc_wr_offset, 3'd4);
      chk("t1_data", dc_wr_data, 64'hDEADBEEF);
      tick();
    end
    dc_wr_ack = 1'b1;
    tick();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    chk("t1_empty_after_ack", empty, 1);
    tick();

    // Fill, then a 9th store while full with an ack in the same cycle.
    for (int i = 0; i < 8; i++) begin
      push_store(16'h1000 + 16'(i * 8), 64'(i + 1), 2'd0);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_full_count", count, 8);
    chk("t2_full_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b1; in_addr = 16'h2000; in_data = 64'h99; in_size = 2'd0;
    dc_wr_ack = 1'b1;
    @(negedge clk);
    chk("t2_ack_full_in_ready", in_ready, 0);
    tick();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    chk("t2_count_after_ack", count, 7);
    chk("t2_in_ready_reopen", in_ready, 1);
    exp_q.push_back({16'h2000, 64'h99, 2'd0});
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count_refill", count, 8);
    tick();
    dc_wr_ack = 1'b1;
    repeat (8) tick();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    chk("t2_drained", empty, 1);
    tick();

    // Forwarding from a DOUBLE.
    push_store(16'h0100, 64'h1122334455667788, 2'd3);
    tick();
    in_valid = 1'b0;
    set_load(1'b1, 16'h0102, 2'd1);
    @(negedge clk);
    chk("t3_half_hit", ld_fwd_hit, 1);
    chk("t3_half_data", ld_fwd_data, 64'h5566);
    chk("t3_half_conflict", ld_conflict, 0);
    set_load(1'b1, 16'h0200, 2'd0);
    #1;
    chk("t3_miss_hit", ld_fwd_hit, 0);
    chk("t3_miss_conflict", ld_conflict, 0);
    set_load(1'b0, 16'h0102, 2'd1);
    #1;
    chk("t3_novalid_hit", ld_fwd_hit, 0);
    chk("t3_novalid_data", ld_fwd_data, 0);
    tick();

    // Younger BYTE partially covering a WORD load.
    push_store(16'h0101, 64'h99, 2'd0);
    tick();
    in_valid = 1'b0;
    set_load(1'b1, 16'h0100, 2'd2);
    @(negedge clk);
    chk("t3_partial_conflict", ld_conflict, 1);
    chk("t3_partial_hit", ld_fwd_hit, 0);
    set_load(1'b1, 16'h0101, 2'd0);
    #1;
    chk("t3_young_hit", ld_fwd_hit, 1);
    chk("t3_young_data", ld_fwd_data, 64'h99);
    set_load(1'b1, 16'h0105, 2'd0);
    #1;
    chk("t3_old_byte_data", ld_fwd_data, 64'h33);
    tick();

    // A store being enqueued is not yet visible.
    push_store(16'h0300, 64'h77, 2'd0);
    set_load(1'b1, 16'h0300, 2'd0);
    @(negedge clk);
    chk("t3_same_cycle_enq_hit", ld_fwd_hit, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_next_cycle_hit", ld_fwd_hit, 1);
    chk("t3_next_cycle_data", ld_fwd_data, 64'h77);
    tick();

    // Head being acked is still visible.
    dc_wr_ack = 1'b1;
    set_load(1'b1, 16'h0102, 2'd1);
    @(negedge clk);
    chk("t3_acked_head_data", ld_fwd_data, 64'h5566);
    tick();
    @(negedge clk);
    chk("t3_after_drain_hit", ld_fwd_hit, 0);
    chk("t3_after_drain_conflict", ld_conflict, 0);
    tick();
    tick();
    dc_wr_ack = 1'b0;
    set_load(1'b0, 16'h0, 2'd0);
    @(negedge clk);
    chk("t3_empty", empty, 1);
    chk("t3_all_writes_seen", exp_q.size(), 0);
    tick();

    // Wrap-around: advance pointers to 6, then straddle slots 7/0.
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_store(16'h0400 + 16'(i * 8), 64'(i), 2'd0);
      dc_wr_ack = 1'b1;
      if (i == 3) begin
        @(negedge clk);
        chk("t4_enq_deq_count", count, 1);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    chk("t4_drained", empty, 1);
    tick();
    push_store(16'h0500, 64'h1, 2'd0);  tick();
    push_store(16'h0200, 64'hAA, 2'd0); tick();
    push_store(16'h0200, 64'hBB, 2'd0); tick();
    push_store(16'h0508, 64'h2, 2'd0);  tick();
    push_store(16'h0510, 64'h3, 2'd0);  tick();
    in_valid = 1'b0;
    set_load(1'b1, 16'h0200, 2'd0);
    @(negedge clk);
    chk("t4_count", count, 5);
    chk("t4_wrap_hit", ld_fwd_hit, 1);
    chk("t4_wrap_data", ld_fwd_data, 64'hBB);
    set_load(1'b1, 16'h0200, 2'd1);
    #1;
    chk("t4_wrap_half_conflict", ld_conflict, 1);
    tick();
    set_load(1'b0, 16'h0, 2'd0);

    // Reset with 4 entries buffered and ack high.
    dc_wr_ack = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_reset_count", count, 4);
    tick();
    rst = 1'b0;
    dc_wr_ack = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_count", count, 0);
    chk("t5_dc_wr_en", dc_wr_en, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_empty", empty, 1);
    tick();

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
